mem_port_arbiter: RTL and testbench

Shares one single-ported, variable-latency memory between the core's instruction-fetch side and its load/store side. Each side gets a hold-until-done request interface. The arbiter grants one side at a time, drives the memory request, and returns read data plus an exception flag with a one-cycle done pulse. It sits between mips_core and the unified memory model, and includes starvation control and a memory-response watchdog.

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the I-fetch, load/store and memory-side signals of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
interface mem_port_arbiter_if;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          i_excpt;

  logic          d_req;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_write_en;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          d_excpt;

  logic          m_req;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_write_en;
  logic          m_ready;
  logic [DW-1:0] m_rdata;
  logic          m_excpt;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_wdata, d_write_en,
           m_ready, m_rdata, m_excpt,
    output i_rdata, i_done, i_excpt, d_rdata, d_done, d_excpt,
           m_req, m_addr, m_wdata, m_write_en
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_wdata, d_write_en,
           m_ready, m_rdata, m_excpt,
    input  i_rdata, i_done, i_excpt, d_rdata, d_done, d_excpt,
           m_req, m_addr, m_wdata, m_write_en
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// with D-priority bounded by a starvation limit and a memory-response watchdog.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy
);
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned SW = 4;
  localparam int unsigned TW = 16;

  typedef enum logic [2:0] {IDLE, BUS_I, BUS_D, RESP_I, RESP_D} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] to_q, to_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [BW-1:0] wmask_q, wmask_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic          i_done_q, i_done_d, d_done_q, d_done_d;
  logic          i_excpt_q, i_excpt_d, d_excpt_q, d_excpt_d;
  logic          m_req_q, m_req_d;
  logic          busy_q, busy_d;
  logic          i_forced;
  logic          to_expired;

  assign i_forced   = (starve_q == SW'(STARVE_LIMIT));
  assign to_expired = (TIMEOUT != 0) && (to_q == TW'(TIMEOUT - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    to_d      = to_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    i_excpt_d = 1'b0;
    d_excpt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.i_req) starve_d = '0;
        if (bus.d_req && !(bus.i_req && i_forced)) begin
          state_d = BUS_D;
          addr_d  = bus.d_addr;
          wdata_d = bus.d_wdata;
          wmask_d = bus.d_write_en;
          to_d    = '0;
          if (bus.i_req) starve_d = SW'(starve_q + 1'b1);
        end else if (bus.i_req) begin
          state_d  = BUS_I;
          addr_d   = bus.i_addr;
          wdata_d  = '0;
          wmask_d  = '0;
          to_d     = '0;
          starve_d = '0;
        end
      end
      BUS_I, BUS_D: begin
        // A memory response in the expiry cycle takes precedence over the watchdog
        if (bus.m_ready || to_expired) begin
          addr_d  = '0;
          wdata_d = '0;
          wmask_d = '0;
          if (state_q == BUS_I) begin
            state_d   = RESP_I;
            i_done_d  = 1'b1;
            i_rdata_d = bus.m_ready ? bus.m_rdata : '0;
            i_excpt_d = bus.m_ready ? bus.m_excpt : 1'b1;
          end else begin
            state_d   = RESP_D;
            d_done_d  = 1'b1;
            d_rdata_d = bus.m_ready ? bus.m_rdata : '0;
            d_excpt_d = bus.m_ready ? bus.m_excpt : 1'b1;
          end
        end else begin
          to_d = TW'(to_q + 1'b1);
        end
      end
      RESP_I, RESP_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase

    m_req_d = (state_d == BUS_I) || (state_d == BUS_D);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      to_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      i_excpt_q <= 1'b0;
      d_excpt_q <= 1'b0;
      m_req_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      to_q      <= to_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      i_excpt_q <= i_excpt_d;
      d_excpt_q <= d_excpt_d;
      m_req_q   <= m_req_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.i_rdata    = i_rdata_q;
  assign bus.i_done     = i_done_q;
  assign bus.i_excpt    = i_excpt_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_done     = d_done_q;
  assign bus.d_excpt    = d_excpt_q;
  assign bus.m_req      = m_req_q;
  assign bus.m_addr     = addr_q;
  assign bus.m_wdata    = wdata_q;
  assign bus.m_write_en = wmask_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized phase scored against a grant-level reference model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic busy, busy0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus  ();
  mem_port_arbiter_if bus0 ();

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );
  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .busy(busy0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the memory: waits for m_req, stalls wait_n cycles, then completes.
  // Returns at the cycle after m_ready, i.e. the expected done cycle.
  task automatic serve(input int wait_n, input logic [31:0] rd, input logic ex,
                       output logic [29:0] a, output logic [31:0] wd,
                       output logic [3:0] we, output int bus_cycles);
    int n;
    bit held;
    n = 0;
    while (!bus.m_req && n < 20) begin
      tick();
      n++;
    end
    chk("grant_seen", 32'(bus.m_req), 32'd1);
    a          = bus.m_addr;
    wd         = bus.m_wdata;
    we         = bus.m_write_en;
    held       = 1'b1;
    bus_cycles = 1;
    for (int k = 0; k < wait_n; k++) begin
      bus.m_ready = 1'b0;
      tick();
      if (!(bus.m_req && bus.m_addr == a && bus.m_wdata == wd &&
            bus.m_write_en == we && !bus.i_done && !bus.d_done)) held = 1'b0;
      if (bus.m_req) bus_cycles++;
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = rd;
    bus.m_excpt = ex;
    tick();
    bus.m_ready = 1'b0;
    bus.m_rdata = $urandom;
    bus.m_excpt = 1'b0;
    chk("bus_hold", 32'(held), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [29:0] a;
    logic [31:0] wd, rd;
    logic [3:0]  we;
    logic        ex, pend_i, pend_d, exp_i;
    int          bc, n, streak, lat;

    reset = 1'b1;
    bus.i_req = 0;  bus.i_addr = '0;
    bus.d_req = 0;  bus.d_addr = '0; bus.d_wdata = '0; bus.d_write_en = '0;
    bus.m_ready = 0; bus.m_rdata = '0; bus.m_excpt = 0;
    bus0.i_req = 0; bus0.i_addr = '0;
    bus0.d_req = 0; bus0.d_addr = '0; bus0.d_wdata = '0; bus0.d_write_en = '0;
    bus0.m_ready = 0; bus0.m_rdata = '0; bus0.m_excpt = 0;
    tick();
    tick();

    chk("rst_m_req",   32'(bus.m_req), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_done",    32'({bus.i_done, bus.d_done}), 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_m_addr",  32'(bus.m_addr), 0);
    reset = 1'b0;

    // Single load, memory ready on first request cycle
    bus.d_req = 1; bus.d_addr = 30'h100; bus.d_write_en = 4'b0000; bus.d_wdata = 32'h0;
    tick();
    chk("load_m_req_c1", 32'(bus.m_req), 1);
    chk("load_m_addr",   32'(bus.m_addr), 32'h100);
    chk("load_m_we",     32'(bus.m_write_en), 0);
    bus.m_ready = 1; bus.m_rdata = 32'hDEADBEEF; bus.m_excpt = 0;
    tick();
    bus.m_ready = 0; bus.d_req = 0;
    chk("load_d_done",   32'(bus.d_done), 1);
    chk("load_d_rdata",  bus.d_rdata, 32'hDEADBEEF);
    chk("load_d_excpt",  32'(bus.d_excpt), 0);
    chk("load_i_done",   32'(bus.i_done), 0);
    chk("load_m_req_c2", 32'(bus.m_req), 0);
    tick();
    chk("load_idle_busy", 32'(busy), 0);
    chk("load_done_drop", 32'(bus.d_done), 0);
    chk("load_rdata_hold", bus.d_rdata, 32'hDEADBEEF);

    // Store with three wait states
    bus.d_req = 1; bus.d_addr = 30'h200; bus.d_write_en = 4'b0011; bus.d_wdata = 32'h12345678;
    serve(3, 32'h0BADF00D, 1'b0, a, wd, we, bc);
    chk("st_bus_cycles", 32'(bc), 4);
    chk("st_m_addr",     32'(a), 32'h200);
    chk("st_m_wdata",    wd, 32'h12345678);
    chk("st_m_we",       32'(we), 32'h3);
    chk("st_d_done",     32'(bus.d_done), 1);
    chk("st_d_excpt",    32'(bus.d_excpt), 0);
    chk("st_d_rdata",    bus.d_rdata, 32'h0BADF00D);
    chk("st_m_req_off",  32'(bus.m_req), 0);
    bus.d_req = 0;
    tick();
    chk("st_we_after",   32'(bus.m_write_en), 0);
    chk("st_idle",       32'(busy), 0);

    // Contention: both held, D yields to I after four consecutive wins
    bus.i_req = 1; bus.i_addr = 30'h00100000;
    bus.d_req = 1; bus.d_addr = 30'h300; bus.d_write_en = 4'b0000;
    streak = 0;
    for (int g = 0; g < 10; g++) begin
      exp_i = (streak == 4);
      serve(g % 2, $urandom, 1'b0, a, wd, we, bc);
      chk("starve_grant_addr", 32'(a), exp_i ? 32'h00100000 : 32'h300);
      chk("starve_done_side", 32'({bus.i_done, bus.d_done}), exp_i ? 32'h2 : 32'h1);
      streak = exp_i ? 0 : streak + 1;
    end
    bus.i_req = 0; bus.d_req = 0;
    tick();

    // Fetch exception, then a clean fetch
    bus.i_req = 1; bus.i_addr = 30'h44;
    serve(1, 32'h11112222, 1'b1, a, wd, we, bc);
    chk("exc_i_done",  32'(bus.i_done), 1);
    chk("exc_i_excpt", 32'(bus.i_excpt), 1);
    chk("exc_d_side",  32'({bus.d_done, bus.d_excpt}), 0);
    bus.i_req = 0;
    tick();
    chk("exc_drop", 32'({bus.i_done, bus.i_excpt}), 0);
    bus.i_req = 1; bus.i_addr = 30'h48;
    serve(0, 32'h33334444, 1'b0, a, wd, we, bc);
    chk("exc2_i_done",  32'(bus.i_done), 1);
    chk("exc2_i_excpt", 32'(bus.i_excpt), 0);
    chk("exc2_i_rdata", bus.i_rdata, 32'h33334444);
    bus.i_req = 0;
    tick();

    // Watchdog with TIMEOUT=8, memory never answers
    bus.d_req = 1; bus.d_addr = 30'h500; bus.d_write_en = 4'b0000;
    tick();
    n = 0;
    while (bus.m_req && n < 20) begin
      n++;
      tick();
    end
    chk("wd_cycles",  32'(n), 8);
    chk("wd_d_done",  32'(bus.d_done), 1);
    chk("wd_d_excpt", 32'(bus.d_excpt), 1);
    chk("wd_d_rdata", bus.d_rdata, 0);
    bus.d_req = 0;
    tick();
    chk("wd_idle", 32'(busy), 0);
    chk("wd_drop", 32'({bus.d_done, bus.d_excpt}), 0);

    // Watchdog disabled: request stays outstanding
    bus0.d_req = 1; bus0.d_addr = 30'h600;
    tick();
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      if (bus0.m_req && !bus0.d_done) n++;
      tick();
    end
    chk("nowd_cycles", 32'(n), 1000);
    chk("nowd_busy",   32'(busy0), 1);
    bus0.d_req = 0;

    // Reset in the second BUS_D cycle
    bus.d_req = 1; bus.d_addr = 30'h700;
    tick();
    chk("rmid_m_req", 32'(bus.m_req), 1);
    tick();
    reset = 1'b1;
    tick();
    chk("rmid_m_req_off", 32'(bus.m_req), 0);
    chk("rmid_busy",      32'(busy), 0);
    chk("rmid_done",      32'({bus.i_done, bus.d_done}), 0);
    chk("rmid_i_rdata",   bus.i_rdata, 0);
    chk("rmid_d_rdata",   bus.d_rdata, 0);
    chk("rmid_dut0_busy", 32'(busy0), 0);
    reset = 1'b0; bus.d_req = 0;
    bus.i_req = 1; bus.i_addr = 30'h800;
    tick();
    chk("rfetch_m_req",  32'(bus.m_req), 1);
    chk("rfetch_m_addr", 32'(bus.m_addr), 32'h800);
    bus.m_ready = 1; bus.m_rdata = 32'hA5A5C3C3; bus.m_excpt = 0;
    tick();
    bus.m_ready = 0; bus.i_req = 0;
    chk("rfetch_i_done",  32'(bus.i_done), 1);
    chk("rfetch_i_rdata", bus.i_rdata, 32'hA5A5C3C3);
    tick();
    chk("rfetch_idle", 32'(busy), 0);

    // Randomized traffic against a grant-level model
    pend_i = 0; pend_d = 0; streak = 0;
    for (int t = 0; t < 60; t++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) begin
        pend_i = 1;
        bus.i_addr = 30'($urandom);
      end
      if (!pend_d && $urandom_range(0, 3) != 0) begin
        pend_d = 1;
        bus.d_addr     = 30'($urandom);
        bus.d_wdata    = $urandom;
        bus.d_write_en = 4'($urandom);
      end
      if (!pend_i && !pend_d) begin
        pend_i = 1;
        bus.i_addr = 30'($urandom);
      end
      bus.i_req = pend_i;
      bus.d_req = pend_d;
      exp_i = pend_i && (!pend_d || streak == 4);
      lat = $urandom_range(0, 4);
      rd  = $urandom;
      ex  = 1'($urandom_range(0, 1));
      serve(lat, rd, ex, a, wd, we, bc);
      chk("rnd_bus_cycles", 32'(bc), 32'(lat + 1));
      if (exp_i) begin
        chk("rnd_i_addr",  32'(a), 32'(bus.i_addr));
        chk("rnd_i_we",    32'(we), 0);
        chk("rnd_i_side",  32'({bus.i_done, bus.d_done, bus.d_excpt}), 32'h4);
        chk("rnd_i_rdata", bus.i_rdata, rd);
        chk("rnd_i_excpt", 32'(bus.i_excpt), 32'(ex));
        streak = 0;
        pend_i = 0;
      end else begin
        chk("rnd_d_addr",  32'(a), 32'(bus.d_addr));
        chk("rnd_d_wdata", wd, bus.d_wdata);
        chk("rnd_d_we",    32'(we), 32'(bus.d_write_en));
        chk("rnd_d_side",  32'({bus.d_done, bus.i_done, bus.i_excpt}), 32'h4);
        chk("rnd_d_rdata", bus.d_rdata, rd);
        chk("rnd_d_excpt", 32'(bus.d_excpt), 32'(ex));
        streak = pend_i ? streak + 1 : 0;
        pend_d = 0;
      end
      bus.i_req = pend_i;
      bus.d_req = pend_d;
    end
    bus.i_req = 0; bus.d_req = 0;
    tick();
    tick();
    chk("final_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
